// File: rtl/ft_cmd_decoder.sv
// Command-frame decoder for the FT600 RX path: validates framed commands, executes
// LED-set / echo / status, and emits a response frame. Define FT_CMD_TIMEOUT_EN for a mid-frame stall timeout.
module ft_cmd_decoder #(
  parameter int unsigned LED_WIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [15:0]          rx_data_i,
  input  logic [1:0]           rx_be_i,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  output logic [15:0]          tx_data_o,
  output logic [1:0]           tx_be_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [LED_WIDTH-1:0] led_o,
  output logic [7:0]           err_count_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    StHunt, StPayload, StCheck, StExec, StRespHdr, StRespPay, StRespCsum
  } state_e;

  localparam logic [3:0] OpSetLed = 4'h1;
  localparam logic [3:0] OpEcho   = 4'h2;
  localparam logic [3:0] OpStatus = 4'h3;

  if (LED_WIDTH < 1 || LED_WIDTH > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ft_cmd_decoder: LED_WIDTH must be 1..16 and TIMEOUT_CYCLES nonzero");
  end

  state_e               state_q;
  logic                 rx_ready_q;
  logic                 tx_valid_q;
  logic [15:0]          tx_data_q;
  logic [LED_WIDTH-1:0] led_q;
  logic [7:0]           err_q;
  logic [3:0]           op_q;
  logic [3:0]           len_q;
  logic [3:0]           rlen_q;
  logic [3:0]           cnt_q;
  logic [15:0]          csum_q;
  logic [15:0]          resp_csum_q;
  logic                 illegal_q;
  logic                 nak_q;
  logic [15:0]          buf_q [16];

  logic        rx_fire, tx_fire, be_ok, hdr_ok, hdr_illegal, to_expire;
  logic [3:0]  hdr_op, hdr_len, exec_rlen, cnt_nxt;
  logic [15:0] exec_hdr, led_ext;
  logic [7:0]  err_inc;

  assign rx_fire = rx_valid_i && rx_ready_q;
  assign tx_fire = tx_valid_q && tx_ready_i;
  assign be_ok   = (rx_be_i == 2'b11);
  assign hdr_ok  = (rx_data_i[15:8] == 8'hA5);
  assign hdr_op  = rx_data_i[7:4];
  assign hdr_len = rx_data_i[3:0];
  assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  assign led_ext = 16'(led_q);
  assign cnt_nxt = cnt_q + 4'd1;

  always_comb begin
    hdr_illegal = 1'b1;
    case (hdr_op)
      OpSetLed: hdr_illegal = (hdr_len != 4'd1);
      OpEcho:   hdr_illegal = 1'b0;
      OpStatus: hdr_illegal = (hdr_len != 4'd0);
      default:  hdr_illegal = 1'b1;
    endcase
  end

  always_comb begin
    exec_rlen = 4'd0;
    case (op_q)
      OpEcho:   exec_rlen = len_q;
      OpStatus: exec_rlen = 4'd2;
      default:  exec_rlen = 4'd0;
    endcase
    exec_hdr = nak_q ? 16'h5AF0 : {8'h5A, op_q, exec_rlen};
  end

`ifdef FT_CMD_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        in_frame;

  assign in_frame  = (state_q == StPayload) || (state_q == StCheck);
  assign to_expire = in_frame && !rx_fire && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || rx_fire || !in_frame) begin
      to_cnt_q <= '0;
    end else if (!to_expire) begin
      to_cnt_q <= to_cnt_q + 32'd1;
    end
  end
`else
  assign to_expire = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StHunt;
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      led_q       <= '0;
      err_q       <= '0;
      op_q        <= '0;
      len_q       <= '0;
      rlen_q      <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      resp_csum_q <= '0;
      illegal_q   <= 1'b0;
      nak_q       <= 1'b0;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
    end else begin
      unique case (state_q)
        StHunt: begin
          rx_ready_q <= 1'b1;
          if (rx_fire) begin
            if (!be_ok || !hdr_ok) begin
              err_q <= err_inc;
            end else begin
              op_q      <= hdr_op;
              len_q     <= hdr_len;
              csum_q    <= rx_data_i;
              illegal_q <= hdr_illegal;
              cnt_q     <= '0;
              state_q   <= (hdr_len == 4'd0) ? StCheck : StPayload;
            end
          end
        end
        StPayload: begin
          if (rx_fire) begin
            if (!be_ok) begin
              err_q   <= err_inc;
              state_q <= StHunt;
            end else begin
              buf_q[cnt_q] <= rx_data_i;
              csum_q       <= csum_q ^ rx_data_i;
              cnt_q        <= cnt_nxt;
              if (cnt_q == len_q - 4'd1) state_q <= StCheck;
            end
          end else if (to_expire) begin
            err_q   <= err_inc;
            state_q <= StHunt;
          end
        end
        StCheck: begin
          if (rx_fire) begin
            if (!be_ok) begin
              err_q   <= err_inc;
              state_q <= StHunt;
            end else begin
              // Illegal op/len frames are still consumed up to here before NAKing.
              nak_q      <= illegal_q || (rx_data_i != csum_q);
              if (illegal_q || (rx_data_i != csum_q)) err_q <= err_inc;
              rx_ready_q <= 1'b0;
              state_q    <= StExec;
            end
          end else if (to_expire) begin
            err_q   <= err_inc;
            state_q <= StHunt;
          end
        end
        StExec: begin
          if (!nak_q && op_q == OpSetLed) led_q <= buf_q[0][LED_WIDTH-1:0];
          if (!nak_q && op_q == OpStatus) begin
            buf_q[0] <= led_ext;
            buf_q[1] <= {8'h00, err_q};
          end
          rlen_q      <= nak_q ? 4'd0 : exec_rlen;
          tx_data_q   <= exec_hdr;
          resp_csum_q <= exec_hdr;
          tx_valid_q  <= 1'b1;
          cnt_q       <= '0;
          state_q     <= StRespHdr;
        end
        StRespHdr: begin
          if (tx_fire) begin
            if (rlen_q == 4'd0) begin
              tx_data_q <= resp_csum_q;
              state_q   <= StRespCsum;
            end else begin
              tx_data_q   <= buf_q[0];
              resp_csum_q <= resp_csum_q ^ buf_q[0];
              state_q     <= StRespPay;
            end
          end
        end
        StRespPay: begin
          if (tx_fire) begin
            if (cnt_q == rlen_q - 4'd1) begin
              tx_data_q <= resp_csum_q;
              state_q   <= StRespCsum;
            end else begin
              tx_data_q   <= buf_q[cnt_nxt];
              resp_csum_q <= resp_csum_q ^ buf_q[cnt_nxt];
              cnt_q       <= cnt_nxt;
            end
          end
        end
        StRespCsum: begin
          if (tx_fire) begin
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
            state_q    <= StHunt;
          end
        end
        default: state_q <= StHunt;
      endcase
    end
  end

  assign rx_ready_o  = rx_ready_q;
  assign tx_data_o   = tx_data_q;
  assign tx_be_o     = 2'b11;
  assign tx_valid_o  = tx_valid_q;
  assign led_o       = led_q;
  assign err_count_o = err_q;
  assign busy_o      = (state_q != StHunt);

endmodule

// File: tb/tb_ft_cmd_decoder.sv
// Directed bench for ft_cmd_decoder: frame execution, NAKs, sync/partial-word errors,
// reset mid-response, and either the stall timeout or indefinite wait.
module tb_ft_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rx_data;
  logic [1:0]  rx_be;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] tx_data;
  logic [1:0]  tx_be;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  led;
  logic [7:0]  err_count;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ft_cmd_decoder #(
    .LED_WIDTH      (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_data_i   (rx_data),
    .rx_be_i     (rx_be),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .tx_data_o   (tx_data),
    .tx_be_o     (tx_be),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .led_o       (led),
    .err_count_o (err_count),
    .busy_o      (busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive one word; returns at the negedge after the accepting posedge.
  task automatic send_word(input logic [15:0] d, input logic [1:0] be);
    int n = 0;
    rx_data  = d;
    rx_be    = be;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rx_accept", 32'(rx_ready), 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic recv_word(input logic [15:0] exp, input bit stall, input string tag);
    int n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(tx_valid), 1);
    check({tag, "_data"}, 32'(tx_data), 32'(exp));
    if (stall) begin
      tx_ready = 1'b0;
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(tx_valid), 1);
      check({tag, "_hold_data"}, 32'(tx_data), 32'(exp));
      check({tag, "_rx_blocked"}, 32'(rx_ready), 0);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic expect_no_tx(input int cycles, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx_valid) seen = 1'b1;
    end
    check(tag, 32'(seen), 0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    rx_data  = '0;
    rx_be    = 2'b11;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_tx_be", 32'(tx_be), 'h3);
    check("rst_led", 32'(led), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rx_ready_after_rst", 32'(rx_ready), 1);

    // SET_LED with tx_ready held high: exact latency and back-to-back response.
    tx_ready = 1'b1;
    send_word(16'hA511, 2'b11);
    send_word(16'h0055, 2'b11);
    send_word(16'hA544, 2'b11);
    check("exec_rx_ready", 32'(rx_ready), 0);
    check("exec_tx_valid", 32'(tx_valid), 0);
    check("exec_led_old", 32'(led), 0);
    @(negedge clk);
    check("setled_hdr_valid", 32'(tx_valid), 1);
    check("setled_hdr", 32'(tx_data), 'h5A10);
    check("setled_led", 32'(led), 'h55);
    @(negedge clk);
    check("setled_csum_valid", 32'(tx_valid), 1);
    check("setled_csum", 32'(tx_data), 'h5A10);
    @(negedge clk);
    check("setled_done_valid", 32'(tx_valid), 0);
    check("setled_done_rx_ready", 32'(rx_ready), 1);
    check("setled_err", 32'(err_count), 0);
    tx_ready = 1'b0;

    // ECHO under backpressure.
    send_word(16'hA522, 2'b11);
    send_word(16'h1234, 2'b11);
    send_word(16'hABCD, 2'b11);
    send_word(16'h1CDB, 2'b11);
    recv_word(16'h5A22, 1'b1, "echo_hdr");
    recv_word(16'h1234, 1'b1, "echo_p0");
    recv_word(16'hABCD, 1'b1, "echo_p1");
    recv_word(16'hE3DB, 1'b1, "echo_csum");
    check("echo_done_rx_ready", 32'(rx_ready), 1);
    check("echo_done_busy", 32'(busy), 0);

    // Bad checksum -> NAK, LED untouched.
    send_word(16'hA511, 2'b11);
    send_word(16'h0055, 2'b11);
    send_word(16'h0000, 2'b11);
    recv_word(16'h5AF0, 1'b0, "badcs_hdr");
    recv_word(16'h5AF0, 1'b0, "badcs_csum");
    check("badcs_led", 32'(led), 'h55);
    check("badcs_err", 32'(err_count), 1);

    // STATUS with len=1 is illegal but consumed through its (correct) checksum.
    send_word(16'hA531, 2'b11);
    send_word(16'h0000, 2'b11);
    send_word(16'hA531, 2'b11);
    recv_word(16'h5AF0, 1'b0, "illegal_hdr");
    recv_word(16'h5AF0, 1'b0, "illegal_csum");
    check("illegal_err", 32'(err_count), 2);

    do_reset();
    check("rst2_led", 32'(led), 0);
    check("rst2_err", 32'(err_count), 0);

    // Sync error, then SET_LED and STATUS.
    send_word(16'h1234, 2'b11);
    expect_no_tx(4, "sync_no_tx");
    check("sync_err", 32'(err_count), 1);
    check("sync_busy", 32'(busy), 0);
    send_word(16'hA511, 2'b11);
    send_word(16'h00C3, 2'b11);
    send_word(16'hA5D2, 2'b11);
    recv_word(16'h5A10, 1'b0, "setc3_hdr");
    recv_word(16'h5A10, 1'b0, "setc3_csum");
    check("setc3_led", 32'(led), 'hC3);
    send_word(16'hA530, 2'b11);
    send_word(16'hA530, 2'b11);
    recv_word(16'h5A32, 1'b0, "status_hdr");
    recv_word(16'h00C3, 1'b0, "status_led");
    recv_word(16'h0001, 1'b0, "status_err");
    recv_word(16'h5AF0, 1'b0, "status_csum");

    // Partial word mid-frame: dropped, no response.
    send_word(16'hA511, 2'b11);
    send_word(16'h0055, 2'b01);
    expect_no_tx(4, "partial_no_tx");
    check("partial_err", 32'(err_count), 2);
    check("partial_busy", 32'(busy), 0);
    check("partial_led", 32'(led), 'hC3);

    // Reset while a response is pending.
    send_word(16'hA530, 2'b11);
    send_word(16'hA530, 2'b11);
    @(negedge clk);
    check("midresp_valid", 32'(tx_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx_valid", 32'(tx_valid), 0);
    check("midrst_tx_data", 32'(tx_data), 0);
    check("midrst_led", 32'(led), 0);
    check("midrst_err", 32'(err_count), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_rx_ready", 32'(rx_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rx_ready_after", 32'(rx_ready), 1);
    expect_no_tx(3, "midrst_no_tx");

`ifdef FT_CMD_TIMEOUT_EN
    // Stall in PAYLOAD for 16 cycles -> back to HUNT, no response.
    begin
      logic seen = 1'b0;
      send_word(16'hA522, 2'b11);
      send_word(16'h1234, 2'b11);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (tx_valid) seen = 1'b1;
      end
      check("to_still_busy", 32'(busy), 1);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (tx_valid) seen = 1'b1;
      end
      check("to_hunt", 32'(busy), 0);
      check("to_err", 32'(err_count), 1);
      check("to_no_tx", 32'(seen), 0);
    end
    send_word(16'hA511, 2'b11);
    send_word(16'h0055, 2'b11);
    send_word(16'hA544, 2'b11);
    recv_word(16'h5A10, 1'b0, "to_setled_hdr");
    recv_word(16'h5A10, 1'b0, "to_setled_csum");
    check("to_setled_led", 32'(led), 'h55);
`else
    // Without the timeout a partial frame waits indefinitely and can still complete.
    send_word(16'hA522, 2'b11);
    send_word(16'h1234, 2'b11);
    expect_no_tx(40, "wait_no_tx");
    check("wait_busy", 32'(busy), 1);
    check("wait_err", 32'(err_count), 0);
    send_word(16'hABCD, 2'b11);
    send_word(16'h1CDB, 2'b11);
    recv_word(16'h5A22, 1'b0, "wait_hdr");
    recv_word(16'h1234, 1'b0, "wait_p0");
    recv_word(16'hABCD, 1'b0, "wait_p1");
    recv_word(16'hE3DB, 1'b0, "wait_csum");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
